// File: rtl/ins_mem_loadable.sv
// rtl/ins_mem_loadable.sv - instruction memory with 1-cycle registered fetch and word-serial program load
// Fetches are suppressed while a load is in progress so the decoder never sees a half-written program.
module ins_mem_loadable #(
   parameter int                   INS_WIDTH  = 19,
   parameter int                   ADDR_WIDTH = 12,
   parameter int                   DEPTH      = 4096,
   parameter logic [INS_WIDTH-1:0] NOP_WORD   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  stall,
   output logic [INS_WIDTH-1:0]  ins_out,
   output logic                  ins_valid,
   output logic                  addr_err,
   input  logic                  load_start,
   input  logic [ADDR_WIDTH-1:0] load_base,
   input  logic [ADDR_WIDTH:0]   load_len,
   input  logic [INS_WIDTH-1:0]  load_data,
   input  logic                  load_valid,
   output logic                  load_ready,
   output logic                  load_done,
   output logic                  busy
);

   localparam int                    IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0]   DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_W  = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [ADDR_WIDTH:0]   ONE_W   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH:0]   remaining;
   logic [INS_WIDTH-1:0]  mem [0:DEPTH-1];

   logic in_range;
   logic beat;

   assign in_range   = {1'b0, address} < DEPTH_W;
   assign beat       = (state == LOAD) && load_valid;

   // Handshake outputs are pure decodes of the state register, so they are glitch-free.
   assign load_ready = (state == LOAD);
   assign busy       = (state == LOAD);
   assign load_done  = (state == DONE);

   // The array has no reset so it maps onto block RAM and survives an aborted load.
   always_ff @(posedge clk) begin
      if (beat) begin
         mem[wr_ptr[IDX_W-1:0]] <= load_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         remaining <= '0;
         ins_out   <= '0;
         ins_valid <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (load_start) begin
                  if (load_len == '0) begin
                     state <= DONE;
                  end else begin
                     state     <= LOAD;
                     wr_ptr    <= ADDR_WIDTH'({1'b0, load_base} % DEPTH_W);
                     remaining <= load_len;
                  end
               end
            end
            LOAD: begin
               if (load_valid) begin
                  wr_ptr    <= (wr_ptr == LAST_W) ? '0 : wr_ptr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == ONE_W) begin
                     state <= DONE;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

         // The state check uses the pre-edge state: a fetch issued alongside load_start
         // still reads the old program.
         if (!stall) begin
            if (rd_en && (state != LOAD)) begin
               ins_valid <= 1'b1;
               if (in_range) begin
                  ins_out  <= mem[address[IDX_W-1:0]];
                  addr_err <= 1'b0;
               end else begin
                  ins_out  <= NOP_WORD;
                  addr_err <= 1'b1;
               end
            end else begin
               ins_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_ins_mem_loadable.sv
// tb/tb_ins_mem_loadable.sv - directed self-checking bench for ins_mem_loadable
// Uses an 8-word memory with 4-bit addresses so wrap and out-of-range cases are reachable.
module tb_ins_mem_loadable;

   localparam int              IW  = 19;
   localparam int              AW  = 4;
   localparam int              DEP = 8;
   localparam logic [IW-1:0]   NOP = 19'h12345;

   logic          clk = 1'b0;
   logic          rst;
   logic          rd_en;
   logic [AW-1:0] address;
   logic          stall;
   logic [IW-1:0] ins_out;
   logic          ins_valid;
   logic          addr_err;
   logic          load_start;
   logic [AW-1:0] load_base;
   logic [AW:0]   load_len;
   logic [IW-1:0] load_data;
   logic          load_valid;
   logic          load_ready;
   logic          load_done;
   logic          busy;

   int tests = 0;
   int fails = 0;

   ins_mem_loadable #(.INS_WIDTH(IW), .ADDR_WIDTH(AW), .DEPTH(DEP), .NOP_WORD(NOP)) dut (
      .clk(clk), .rst(rst), .rd_en(rd_en), .address(address), .stall(stall),
      .ins_out(ins_out), .ins_valid(ins_valid), .addr_err(addr_err),
      .load_start(load_start), .load_base(load_base), .load_len(load_len),
      .load_data(load_data), .load_valid(load_valid), .load_ready(load_ready),
      .load_done(load_done), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load(input logic [AW-1:0] base, input logic [AW:0] len);
      load_start = 1'b1;
      load_base  = base;
      load_len   = len;
      tick();
      load_start = 1'b0;
   endtask

   task automatic beat(input logic [IW-1:0] d);
      load_valid = 1'b1;
      load_data  = d;
      tick();
      load_valid = 1'b0;
   endtask

   task automatic fetch(input logic [AW-1:0] a);
      rd_en   = 1'b1;
      address = a;
      tick();
      rd_en   = 1'b0;
   endtask

   task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic test_power_on();
      rst = 1'b1; rd_en = 1'b0; address = '0; stall = 1'b0;
      load_start = 1'b0; load_base = '0; load_len = '0; load_data = '0; load_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("por_ins_valid", {18'd0, ins_valid}, 19'd0);
      chk("por_ins_out", ins_out, 19'd0);
      chk("por_busy", {18'd0, busy}, 19'd0);
      chk("por_load_ready", {18'd0, load_ready}, 19'd0);
      chk("por_load_done", {18'd0, load_done}, 19'd0);
   endtask

   task automatic test_basic_load();
      start_load(4'd0, 5'd3);
      chk("basic_busy", {18'd0, busy}, 19'd1);
      chk("basic_ready", {18'd0, load_ready}, 19'd1);
      beat(19'h00700);
      tick();
      beat(19'h00100);
      tick();
      chk("basic_not_done_early", {18'd0, load_done}, 19'd0);
      beat(19'h29914);
      chk("basic_done_pulse", {18'd0, load_done}, 19'd1);
      chk("basic_busy_in_done", {18'd0, busy}, 19'd0);
      tick();
      chk("basic_done_one_cycle", {18'd0, load_done}, 19'd0);
      fetch(4'd0);
      chk("basic_f0", ins_out, 19'h00700);
      chk("basic_f0_valid", {18'd0, ins_valid}, 19'd1);
      fetch(4'd1);
      chk("basic_f1", ins_out, 19'h00100);
      fetch(4'd2);
      chk("basic_f2", ins_out, 19'h29914);
      chk("basic_f2_err", {18'd0, addr_err}, 19'd0);
      tick();
      chk("basic_idle_valid", {18'd0, ins_valid}, 19'd0);
      chk("basic_idle_hold", ins_out, 19'h29914);
   endtask

   task automatic test_reset();
      rd_en = 1'b1; address = 4'd2;
      tick();
      chk("rst_pre_valid", {18'd0, ins_valid}, 19'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_out", ins_out, 19'd0);
      chk("rst_async_valid", {18'd0, ins_valid}, 19'd0);
      chk("rst_async_busy", {18'd0, busy}, 19'd0);
      tick();
      rst = 1'b0; rd_en = 1'b0;
      tick();
      chk("rst_post_busy", {18'd0, busy}, 19'd0);
      chk("rst_post_ready", {18'd0, load_ready}, 19'd0);
      fetch(4'd2);
      chk("rst_mem_kept", ins_out, 19'h29914);
   endtask

   task automatic test_wrap();
      start_load(4'd6, 5'd4);
      beat(19'h1A1A1);
      beat(19'h2B2B2);
      beat(19'h3C3C3);
      beat(19'h4D4D4);
      chk("wrap_done", {18'd0, load_done}, 19'd1);
      tick();
      fetch(4'd6); chk("wrap_m6", ins_out, 19'h1A1A1);
      fetch(4'd7); chk("wrap_m7", ins_out, 19'h2B2B2);
      fetch(4'd0); chk("wrap_m0", ins_out, 19'h3C3C3);
      fetch(4'd1); chk("wrap_m1", ins_out, 19'h4D4D4);
      fetch(4'd2); chk("wrap_m2_untouched", ins_out, 19'h29914);
   endtask

   task automatic test_stall_range();
      start_load(4'd13, 5'd1);  // base 13 reduces to 5 modulo 8
      beat(19'h55555);
      tick();
      fetch(4'd5);
      chk("range_m5", ins_out, 19'h55555);
      stall = 1'b1; rd_en = 1'b1; address = 4'd9;
      tick(); tick();
      chk("stall_hold_out", ins_out, 19'h55555);
      chk("stall_hold_valid", {18'd0, ins_valid}, 19'd1);
      chk("stall_hold_err", {18'd0, addr_err}, 19'd0);
      stall = 1'b0;
      tick();
      chk("range_nop", ins_out, NOP);
      chk("range_err", {18'd0, addr_err}, 19'd1);
      chk("range_valid", {18'd0, ins_valid}, 19'd1);
      rd_en = 1'b0;
      tick();
      chk("range_idle_valid", {18'd0, ins_valid}, 19'd0);
      chk("range_idle_hold", ins_out, NOP);
      fetch(4'd7);
      chk("range_err_clear", {18'd0, addr_err}, 19'd0);
      chk("range_m7", ins_out, 19'h2B2B2);
   endtask

   task automatic test_load_block();
      rd_en = 1'b1; address = 4'd0;
      start_load(4'd0, 5'd2);
      chk("blk_preload_fetch", ins_out, 19'h3C3C3);
      chk("blk_preload_valid", {18'd0, ins_valid}, 19'd1);
      chk("blk_busy", {18'd0, busy}, 19'd1);
      rd_en = 1'b1;
      beat(19'h0F0F0);
      chk("blk_fetch_in_load", {18'd0, ins_valid}, 19'd0);
      rd_en = 1'b1;
      beat(19'h06060);
      chk("blk_fetch_in_load2", {18'd0, ins_valid}, 19'd0);
      chk("blk_done", {18'd0, load_done}, 19'd1);
      fetch(4'd0);
      chk("blk_fetch_in_done", ins_out, 19'h0F0F0);
      chk("blk_fetch_in_done_v", {18'd0, ins_valid}, 19'd1);
      start_load(4'd5, 5'd0);
      chk("zero_done", {18'd0, load_done}, 19'd1);
      chk("zero_busy", {18'd0, busy}, 19'd0);
      tick();
      chk("zero_done_once", {18'd0, load_done}, 19'd0);
      fetch(4'd5); chk("zero_m5_kept", ins_out, 19'h55555);
      fetch(4'd1); chk("blk_m1", ins_out, 19'h06060);
   endtask

   task automatic test_reset_mid_load();
      logic seen_done;
      start_load(4'd2, 5'd5);
      beat(19'h7E7E7);
      beat(19'h18181);
      #2 rst = 1'b1;
      #1;
      chk("mid_busy", {18'd0, busy}, 19'd0);
      chk("mid_ready", {18'd0, load_ready}, 19'd0);
      seen_done = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         load_valid = 1'b1; load_data = 19'h7FFFF;
         tick();
         if (load_done) seen_done = 1'b1;
      end
      load_valid = 1'b0;
      chk("mid_no_done", {18'd0, seen_done}, 19'd0);
      chk("mid_idle", {18'd0, busy}, 19'd0);
      fetch(4'd2); chk("mid_m2", ins_out, 19'h7E7E7);
      fetch(4'd3); chk("mid_m3", ins_out, 19'h18181);
      fetch(4'd5); chk("mid_m5", ins_out, 19'h55555);
      fetch(4'd6); chk("mid_m6", ins_out, 19'h1A1A1);
      fetch(4'd0); chk("mid_m0", ins_out, 19'h0F0F0);
   endtask

   initial begin
      test_power_on();
      test_basic_load();
      test_reset();
      test_wrap();
      test_stall_range();
      test_load_block();
      test_reset_mid_load();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ins_mem_loadable.md
Name: ins_mem_loadable

Overview:
- Parametrised instruction memory with registered (1-cycle) read and a word-serial program-load port.
- Software or a bench can reprogram it at run time; no source edits are needed.
- Sits between the PC/fetch stage and the decoder.
- Adds a load state machine, fetch stall hold, out-of-range detection and address wrap.

Parameters:
- INS_WIDTH, 19, instruction word width in bits.
- ADDR_WIDTH, 12, fetch/load address width.
- DEPTH, 4096, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_WIDTH.
- NOP_WORD, 0, word returned for out-of-range fetches.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- rd_en  in  1  fetch request.
- address  in  ADDR_WIDTH  fetch address.
- stall  in  1  hold current fetch output.
- ins_out  out  INS_WIDTH  fetched instruction (registered).
- ins_valid  out  1  ins_out holds a completed fetch.
- addr_err  out  1  last fetch was out of range (address >= DEPTH).
- load_start  in  1  begin a load (sampled in IDLE only).
- load_base  in  ADDR_WIDTH  first write address.
- load_len  in  ADDR_WIDTH+1  number of words to write.
- load_data  in  INS_WIDTH  word to write.
- load_valid  in  1  load_data is valid.
- load_ready  out  1  block accepts load_data this cycle.
- load_done  out  1  one-cycle pulse when a load completes.
- busy  out  1  high in LOAD state.

Behaviour:
- Reset (async, rst=1):
  - ins_out=0, ins_valid=0, addr_err=0, load_ready=0, load_done=0, busy=0; FSM goes to IDLE.
  - The memory array is NOT cleared.
- FSM has three states: IDLE, LOAD, DONE.
  - IDLE -> LOAD on load_start=1 with load_len != 0. Latch wr_ptr=load_base and remaining=load_len.
  - IDLE -> DONE on load_start=1 with load_len=0. No writes occur.
  - LOAD: load_ready=1 and busy=1.
    - Each cycle with load_valid&&load_ready: mem[wr_ptr] <= load_data, wr_ptr advances, remaining decrements.
    - Move to DONE when the transfer that brings remaining to 0 is accepted.
    - load_start is ignored in LOAD.
  - DONE: load_done=1 for exactly one cycle, then return to IDLE.
- Write address wrap: wr_ptr increments modulo DEPTH, so the word after DEPTH-1 goes to 0. load_base >= DEPTH is reduced modulo DEPTH when latched.
- Fetch is performed only in IDLE and DONE.
  - When rd_en=1 and stall=0, the next edge registers the result:
    - address < DEPTH: ins_out=mem[address], addr_err=0.
    - address >= DEPTH: ins_out=NOP_WORD, addr_err=1.
    - In both cases ins_valid=1.
  - When rd_en=0 and stall=0: ins_valid=0 next cycle; ins_out holds its value.
  - When stall=1: ins_out, ins_valid and addr_err hold regardless of rd_en, address or state.
- Fetch while in LOAD (stall=0): the fetch is not performed and ins_valid=0 next cycle, so fetch never observes a partially loaded program.
- Simultaneous fetch and load_start in IDLE: the fetch completes from the pre-load contents and the load begins next cycle.
- Reset mid-load: abort to IDLE, no load_done pulse; words already written are retained.
- Latency: fetch is 1 cycle. A load takes load_len accepted beats plus 1 DONE cycle.

Test Plan:
- Reset values: assert rst asynchronously mid-cycle with rd_en=1 -> all outputs 0 immediately; after release, FSM in IDLE and busy=0.
- Basic load and fetch: load_base=0, load_len=3, data 19'h00700, 19'h00100, 19'h29914 with load_valid gaps -> load_done one cycle after third beat. Then fetch addr 0,1,2 -> ins_out matches one cycle later with ins_valid=1.
- Wrap: DEPTH=8, load_base=6, load_len=4, data A,B,C,D -> mem[6]=A, mem[7]=B, mem[0]=C, mem[1]=D, confirmed by fetch.
- Stall and range: DEPTH=8, fetch addr 5 then assert stall while address=9 -> ins_out/ins_valid held. Release stall -> ins_out=NOP_WORD, addr_err=1.
- Load blocking and zero length:
  - Fetch during LOAD -> ins_valid=0.
  - load_len=0 -> load_done pulses on the cycle after start with no writes; memory unchanged.
- Reset mid-load: rst after 2 of 5 beats -> IDLE, no load_done; the 2 written words are readable and the other locations are unchanged.
